// File: rtl/uxn_device_vector_dispatch_if.sv
// Device-RAM read port, event inputs and the vector offer stream of the dispatcher.
// master = dispatcher side, slave = RAM/peripheral/CPU side.
interface uxn_device_vector_dispatch_if;
   logic [15:0] event_req;
   logic [7:0]  ram_addr;
   logic [7:0]  ram_q;
   logic        vec_valid;
   logic [15:0] vec_addr;
   logic [3:0]  vec_dev;
   logic        vec_ready;
   logic [15:0] pending;
   logic        busy;

   modport master (
      input  event_req, ram_q, vec_ready,
      output ram_addr, vec_valid, vec_addr, vec_dev, pending, busy
   );

   modport slave (
      output event_req, ram_q, vec_ready,
      input  ram_addr, vec_valid, vec_addr, vec_dev, pending, busy
   );
endinterface

// File: rtl/uxn_device_vector_dispatch.sv
// Latches device events, fetches {dev,0}/{dev,1} vectors, offers non-zero ones; 4 cycles pending->valid, holds offer until vec_ready.
// UXN_DEVICE_DISPATCH_RR_EN selects round-robin arbitration instead of lowest-index priority.
module uxn_device_vector_dispatch #(
   parameter int NUM_DEV = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   uxn_device_vector_dispatch_if.master  bus
);

   localparam logic [15:0] DEV_MASK = 16'((32'd1 << NUM_DEV) - 32'd1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH_HI,
      S_FETCH_LO,
      S_CAPT_LO,
      S_OFFER
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_pending;
   logic [15:0] w_evt;
   logic [15:0] w_clr;
   logic [3:0]  w_grant;
   logic        w_grant_vld;
   logic        w_vec_nonzero;
   logic [7:0]  r_ram_addr;
   logic [7:0]  w_ram_addr_nxt;
   logic [15:0] r_vec_addr;
   logic [15:0] w_vec_addr_nxt;
   logic [3:0]  r_vec_dev;
   logic [3:0]  w_vec_dev_nxt;
   logic        r_vec_valid;
   logic        w_vec_valid_nxt;

   assign w_evt         = bus.event_req & DEV_MASK;
   assign w_grant_vld   = (r_state == S_IDLE) && (r_pending != 16'h0);
   assign w_clr         = w_grant_vld ? (16'h1 << w_grant) : 16'h0;
   assign w_vec_nonzero = ({r_vec_addr[15:8], bus.ram_q} != 16'h0);

`ifdef UXN_DEVICE_DISPATCH_RR_EN
   logic [3:0] r_last;

   // Descending scan so the pending device closest after r_last is assigned last.
   always_comb begin
      int j;
      w_grant = 4'h0;
      j       = 0;
      for (int i = NUM_DEV - 1; i >= 0; i--) begin
         j = int'(r_last) + 1 + i;
         if (j >= NUM_DEV) j = j - NUM_DEV;
         if (r_pending[4'(j)]) w_grant = 4'(j);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)              r_last <= 4'h0;
      else if (w_grant_vld) r_last <= w_grant;
   end
`else
   always_comb begin
      w_grant = 4'h0;
      for (int i = NUM_DEV - 1; i >= 0; i--) begin
         if (r_pending[4'(i)]) w_grant = 4'(i);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:     if (w_grant_vld) w_state_nxt = S_FETCH_HI;
         S_FETCH_HI: w_state_nxt = S_FETCH_LO;
         S_FETCH_LO: w_state_nxt = S_CAPT_LO;
         S_CAPT_LO:  w_state_nxt = w_vec_nonzero ? S_OFFER : S_IDLE;
         S_OFFER:    if (bus.vec_ready) w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   // RAM data lags the address by one edge, so each byte is captured one state after its address.
   always_comb begin
      w_ram_addr_nxt  = r_ram_addr;
      w_vec_addr_nxt  = r_vec_addr;
      w_vec_dev_nxt   = r_vec_dev;
      w_vec_valid_nxt = r_vec_valid;
      case (r_state)
         S_IDLE: begin
            if (w_grant_vld) begin
               w_vec_dev_nxt  = w_grant;
               w_ram_addr_nxt = {w_grant, 4'h0};
            end
         end
         S_FETCH_HI: w_ram_addr_nxt = {r_vec_dev, 4'h1};
         S_FETCH_LO: w_vec_addr_nxt[15:8] = bus.ram_q;
         S_CAPT_LO: begin
            w_vec_addr_nxt[7:0] = bus.ram_q;
            w_vec_valid_nxt     = w_vec_nonzero;
         end
         S_OFFER:    if (bus.vec_ready) w_vec_valid_nxt = 1'b0;
         default:    w_vec_valid_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending   <= 16'h0;
         r_ram_addr  <= 8'h0;
         r_vec_addr  <= 16'h0;
         r_vec_dev   <= 4'h0;
         r_vec_valid <= 1'b0;
      end else begin
         r_pending   <= (r_pending & ~w_clr) | w_evt;
         r_ram_addr  <= w_ram_addr_nxt;
         r_vec_addr  <= w_vec_addr_nxt;
         r_vec_dev   <= w_vec_dev_nxt;
         r_vec_valid <= w_vec_valid_nxt;
      end
   end

   assign bus.ram_addr  = r_ram_addr;
   assign bus.vec_addr  = r_vec_addr;
   assign bus.vec_dev   = r_vec_dev;
   assign bus.vec_valid = r_vec_valid;
   assign bus.pending   = r_pending;
   assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uxn_device_vector_dispatch.sv
// Bench for uxn_device_vector_dispatch: constant vector table, directed corner sequences, random traffic vs. a transaction model.
`timescale 1ns/1ps
module tb_uxn_device_vector_dispatch;
   localparam int NDEV = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uxn_device_vector_dispatch_if bus();
   uxn_device_vector_dispatch #(.NUM_DEV(NDEV)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Registered-read device RAM.
   logic [7:0] ram [256];
   always @(posedge clk) bus.ram_q <= ram[bus.ram_addr];

   int vectors = 0;
   int miscompares = 0;

   // Transaction model: phase 0 idle, 1..3 edges since grant, 4 offering.
   bit m_pend [NDEV];
   int m_phase = 0;
   int m_dev = 0;
   int m_vec = 0;
   int m_last = 0;
   int dut_served [$];

   typedef struct {
      logic [15:0] evt;
      logic        rdy;
      logic        e_valid;
      logic        e_busy;
      logic [15:0] e_pend;
      logic [15:0] e_addr;
      logic [3:0]  e_dev;
   } vec_t;
   vec_t tbl [11];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic int arb();
      for (int i = 0; i < NDEV; i++) begin
         int j;
`ifdef UXN_DEVICE_DISPATCH_RR_EN
         j = (m_last + 1 + i) % NDEV;
`else
         j = i;
`endif
         if (m_pend[j]) return j;
      end
      return -1;
   endfunction

   function automatic logic [15:0] m_pend_vec();
      logic [15:0] v;
      v = 16'h0;
      for (int k = 0; k < NDEV; k++) v[k] = m_pend[k];
      return v;
   endfunction

   task automatic model_edge(input logic r, input logic [15:0] evt, input logic rdy);
      int g;
      g = -1;
      if (r) begin
         for (int k = 0; k < NDEV; k++) m_pend[k] = 1'b0;
         m_phase = 0;
         m_last  = 0;
      end else begin
         case (m_phase)
            0: begin
               g = arb();
               if (g >= 0) begin
                  m_dev   = g;
                  m_last  = g;
                  m_vec   = int'(ram[g*16]) * 256 + int'(ram[g*16+1]);
                  m_phase = 1;
               end
            end
            1, 2: m_phase++;
            3: m_phase = (m_vec == 0) ? 0 : 4;
            default: if (rdy) m_phase = 0;
         endcase
         for (int k = 0; k < NDEV; k++) begin
            if (k == g) m_pend[k] = 1'b0;
            if (evt[k]) m_pend[k] = 1'b1;
         end
      end
   endtask

   // Called at a negedge: apply inputs, clock one edge, compare against the model at the next negedge.
   task automatic step(input logic [15:0] evt, input logic rdy, input logic r = 1'b0);
      logic        ev;
      logic [63:0] got;
      logic [63:0] exp;
      bus.event_req = evt;
      bus.vec_ready = rdy;
      rst = r;
      if (!r && bus.vec_valid && rdy) dut_served.push_back(int'(bus.vec_dev));
      @(posedge clk);
      model_edge(r, evt, rdy);
      @(negedge clk);
      ev  = (m_phase == 4);
      got = {26'h0, bus.vec_valid, bus.busy, bus.pending,
             bus.vec_valid ? bus.vec_addr : 16'h0, bus.vec_valid ? bus.vec_dev : 4'h0};
      exp = {26'h0, ev, (m_phase != 0), m_pend_vec(),
             ev ? 16'(m_vec) : 16'h0, ev ? 4'(m_dev) : 4'h0};
      check("model", got, exp);
   endtask

   task automatic wait_valid(input logic rdy, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (bus.vec_valid) begin
            ok = 1'b1;
            break;
         end
         step(16'h0, rdy);
      end
      check("wait_valid", 64'(ok), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_order [4];
      bit pulsed;
      bit saw_valid;
      logic [15:0] hold_addr;
      logic [3:0]  hold_dev;

      for (int a = 0; a < 256; a++) ram[a] = 8'h00;
      bus.event_req = 16'h0;
      bus.vec_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      step(16'h0, 1'b0, 1'b1);
      step(16'hFFFF, 1'b0, 1'b1);

      // Reset state, with events ignored during reset.
      check("rst_ram_addr", 64'(bus.ram_addr), 64'h0);
      check("rst_vec_addr", 64'(bus.vec_addr), 64'h0);
      check("rst_vec_dev",  64'(bus.vec_dev),  64'h0);
      check("rst_outputs",  64'({bus.vec_valid, bus.busy, bus.pending}), 64'h0);

      // Table: device 2 vector 0x0123, then zero vector on device 5.
      ram[8'h20] = 8'h01; ram[8'h21] = 8'h23;
      tbl[0]  = '{16'h0004, 1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000, 4'h0};
      tbl[1]  = '{16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 4'h0};
      tbl[2]  = '{16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 4'h0};
      tbl[3]  = '{16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 4'h0};
      tbl[4]  = '{16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0123, 4'h2};
      tbl[5]  = '{16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0};
      tbl[6]  = '{16'h0020, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 4'h0};
      tbl[7]  = '{16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 4'h0};
      tbl[8]  = '{16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 4'h0};
      tbl[9]  = '{16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 4'h0};
      tbl[10] = '{16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0};
      for (int i = 0; i < 11; i++) begin
         step(tbl[i].evt, tbl[i].rdy);
         check($sformatf("tbl[%0d]_ctl", i), 64'({bus.vec_valid, bus.busy, bus.pending}),
               64'({tbl[i].e_valid, tbl[i].e_busy, tbl[i].e_pend}));
         if (tbl[i].e_valid)
            check($sformatf("tbl[%0d]_vec", i), 64'({bus.vec_addr, bus.vec_dev}),
                  64'({tbl[i].e_addr, tbl[i].e_dev}));
      end

      // Stalled offer on device 7 while device 3 raises an event.
      ram[8'h70] = 8'hBE; ram[8'h71] = 8'hEF;
      ram[8'h30] = 8'h12; ram[8'h31] = 8'h34;
      step(16'h0080, 1'b0);
      wait_valid(1'b0, 8);
      hold_addr = bus.vec_addr;
      hold_dev  = bus.vec_dev;
      check("stall_first", 64'({hold_addr, hold_dev}), 64'({16'hBEEF, 4'h7}));
      for (int i = 0; i < 10; i++) begin
         step((i == 3) ? 16'h0008 : 16'h0000, 1'b0);
         check("stall_hold", 64'({bus.vec_valid, bus.vec_addr, bus.vec_dev}), 64'({1'b1, 16'hBEEF, 4'h7}));
      end
      check("stall_pend3", 64'(bus.pending[3]), 64'd1);
      step(16'h0, 1'b1);
      wait_valid(1'b0, 8);
      check("stall_next", 64'({bus.vec_addr, bus.vec_dev}), 64'({16'h1234, 4'h3}));
      step(16'h0, 1'b1);

      // Arbitration order for devices 1, 3, 9 with 1 and 9 re-raised while 3 is offered.
      ram[8'h10] = 8'hA1; ram[8'h11] = 8'h01;
      ram[8'h90] = 8'h09; ram[8'h91] = 8'h99;
`ifdef UXN_DEVICE_DISPATCH_RR_EN
      exp_order = '{1, 3, 9, 1};
`else
      exp_order = '{1, 3, 1, 9};
`endif
      step(16'h0, 1'b0, 1'b1);
      dut_served.delete();
      pulsed = 1'b0;
      step(16'h020A, 1'b1);
      for (int i = 0; i < 60 && dut_served.size() < 4; i++) begin
         if (!pulsed && bus.vec_valid && bus.vec_dev == 4'h3) begin
            pulsed = 1'b1;
            step(16'h0202, 1'b1);
         end else begin
            step(16'h0, 1'b1);
         end
      end
      check("order_count", 64'(dut_served.size()), 64'd4);
      for (int i = 0; i < 4 && i < dut_served.size(); i++)
         check($sformatf("order[%0d]", i), 64'(dut_served[i]), 64'(exp_order[i]));

      // Event for device 4 on the same edge it is granted: set beats clear.
      for (int i = 0; i < 20 && (bus.busy || bus.pending != 16'h0); i++) step(16'h0, 1'b1);
      ram[8'h40] = 8'h44; ram[8'h41] = 8'h40;
      dut_served.delete();
      step(16'h0010, 1'b1);
      step(16'h0010, 1'b1);
      check("setwin_pend4", 64'({bus.busy, bus.pending[4]}), 64'({1'b1, 1'b1}));
      for (int i = 0; i < 30 && dut_served.size() < 2; i++) step(16'h0, 1'b1);
      check("setwin_count", 64'(dut_served.size()), 64'd2);
      for (int i = 0; i < 2 && i < dut_served.size(); i++)
         check("setwin_dev", 64'(dut_served[i]), 64'd4);

      // Reset in FETCH_LO with device 6 pending again.
      for (int i = 0; i < 20 && (bus.busy || bus.pending != 16'h0); i++) step(16'h0, 1'b1);
      ram[8'h60] = 8'h66; ram[8'h61] = 8'h01;
      step(16'h0040, 1'b0);
      step(16'h0000, 1'b0);
      step(16'h0040, 1'b0);
      check("midrst_pre", 64'({bus.busy, bus.pending}), 64'({1'b1, 16'h0040}));
      step(16'h0, 1'b0, 1'b1);
      check("midrst_post", 64'({bus.ram_addr, bus.vec_valid, bus.vec_addr, bus.vec_dev, bus.busy, bus.pending}), 64'h0);
      saw_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(16'h0, 1'b1);
         if (bus.vec_valid) saw_valid = 1'b1;
      end
      check("midrst_novalid", 64'(saw_valid), 64'd0);

      // Random traffic against the model; RAM only changes while reset is applied.
      for (int d = 0; d < NDEV; d++) begin
         if ($urandom_range(0, 3) == 0) begin
            ram[d*16] = 8'h00; ram[d*16+1] = 8'h00;
         end else begin
            ram[d*16] = 8'($urandom); ram[d*16+1] = 8'($urandom);
         end
      end
      step(16'h0, 1'b0, 1'b1);
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] evt;
         evt = 16'h0;
         if ($urandom_range(0, 5) == 0) evt = 16'(1) << $urandom_range(0, 15);
         if ($urandom_range(0, 19) == 0) evt = evt | 16'($urandom);
         step(evt, $urandom_range(0, 2) != 0, $urandom_range(0, 499) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/uxn_device_vector_dispatch.md
# uxn_device_vector_dispatch

Reads device vectors out of the shared 256-byte device RAM through its read-only port and hands them to the CPU sequencer as a valid/ready stream. Peripherals (screen, controller, mouse, audio, console) pulse a per-device event line. The block latches the event as pending, arbitrates among pending devices, fetches the device's 16-bit big-endian vector from bytes `{dev,4'h0}` and `{dev,4'h1}`, drops zero vectors, and offers non-zero vectors to the CPU. It is the reader counterpart to the CPU-side write port of the device RAM.

## Interface
Parameters:
- `NUM_DEV`, default 16: number of device slots serviced, 1..16; `event_req` bits at index NUM_DEV and above are ignored.

Ports:
- `clk`  in  1  single clock; the device RAM read port is clocked from the same net.
- `rst`  in  1  reset, synchronous and active-high.
- `event_req`  in  16  one bit per device; a high bit sampled on any edge marks that device pending.
- `ram_addr`  out  8  registered; drives the device RAM read-port address.
- `ram_q`  in  8  device RAM read data; registered in the RAM, so it reflects the address the RAM sampled on the previous edge.
- `vec_valid`  out  1  vector offer valid.
- `vec_addr`  out  16  vector, `{byte0, byte1}`.
- `vec_dev`  out  4  device index of the offered vector.
- `vec_ready`  in  1  CPU accepts the vector.
- `pending`  out  16  pending bitmap; bits NUM_DEV and above read 0.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **Pending register:** `pending <= (pending & ~clr) | event_req_masked`.
  - `clr` is the one-hot grant issued in IDLE.
  - If a set and a clear hit the same bit on the same edge, the set wins, so that device is serviced again.
- **FSM states:** IDLE, FETCH_HI, FETCH_LO, CAPT_LO, OFFER.
  - **IDLE:** if `pending != 0`:
    - grant device d;
    - clear `pending[d]`;
    - `vec_dev <= d`;
    - `ram_addr <= {d,4'h0}`;
    - go to FETCH_HI.
  - **FETCH_HI:** `ram_addr <= {d,4'h1}`; go to FETCH_LO.
  - **FETCH_LO:** `vec_addr[15:8] <= ram_q`; go to CAPT_LO.
  - **CAPT_LO:** `vec_addr[7:0] <= ram_q`.
    - If `{vec_addr[15:8], ram_q} == 0`: go to IDLE; the vector is dropped silently.
    - Otherwise: `vec_valid <= 1`; go to OFFER.
  - **OFFER:** hold `vec_addr` and `vec_dev` stable. On an edge with `vec_ready` high: `vec_valid <= 0`; go to IDLE.
- **Arbitration:** lowest pending index wins. The round-robin variant is described under Configuration.
- **Coherence:** no tear protection. A port-A write to byte 0 or 1 during a fetch may yield a mixed vector. The system keeps the CPU stalled while `busy` is high.
- **`event_req` during `rst`:** ignored.

## Timing
- **Reset values** (one edge with `rst` high):
  - FSM = IDLE;
  - `pending` = 0, `ram_addr` = 0, `vec_valid` = 0, `vec_addr` = 0, `vec_dev` = 0, `busy` = 0;
  - round-robin pointer = 0.
- **Reset mid-operation:** same result from any state. An in-flight fetch or offer is discarded without handshake.
- **Latency:**
  - event sampled at edge E0;
  - grant at E1;
  - high byte captured at E3;
  - `vec_valid` high after E4;
  - 4 cycles from `pending[d]` visible to `vec_valid`.
- **Zero-vector path:** `busy` high for 3 cycles, IDLE after E4.
- **Handshake:** transfer occurs on an edge with `vec_valid && vec_ready`.
  - `vec_ready` while `vec_valid` is low has no effect.
  - `vec_valid` never drops without a transfer, except on `rst`.
- **Back-to-back:** at least one IDLE cycle between offers. Minimum 5-cycle period per serviced vector.
- **Event during service:** accumulates in `pending`. No events are lost, but repeated events for the same device coalesce into one pending bit.

## Configuration
- `UXN_DEVICE_DISPATCH_RR_EN`:
  - **Defined:** round-robin arbitration. Search starts at `(last_grant + 1) mod NUM_DEV`; `last_grant` updates on each grant (including zero-vector drops) and resets to 0. Search starts at 1 after reset.
  - **Undefined:** fixed priority, lowest index first. No pointer register.

## Test plan
- Preload ram[0x20]=0x01, ram[0x21]=0x23, hold `vec_ready` high, pulse `event_req[2]` -> `vec_valid` after E4 with `vec_addr`=0x0123 and `vec_dev`=2; `pending[2]` = 0 after E1; `busy` = 0 after the transfer.
- ram[0x50]=ram[0x51]=0, pulse `event_req[5]` -> `vec_valid` never asserts; FSM back in IDLE 4 cycles later; `pending` = 0.
- Non-zero vector for device 7, `vec_ready` low for 10 cycles, then `event_req[3]` pulsed -> `vec_addr` and `vec_dev` stable throughout, `pending[3]` = 1; after `vec_ready`, device 3 is offered next.
- Non-zero vectors for devices 1, 3, 9, pulsed together, `vec_ready` high -> fixed order 1, 3, 9. With RR: order 1, 3, 9, then `event_req[1]` and `event_req[9]` re-pulsed while 3 is in OFFER -> 9 is served before 1.
- Pulse `event_req[4]` on the edge device 4 is granted -> `pending[4]` stays 1; device 4 is offered twice.
- `rst` asserted for one cycle while in FETCH_LO with `pending[6]` = 1 -> next cycle all outputs at reset values, `pending` = 0, no `vec_valid`.
